// File: rtl/uart_rx_controller.sv
// UART receive sequencer: start detect, mid-bit sampling, deserializer write strobes, stop check.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data and the stop bit.
module uart_rx_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          s_tick,
  input  logic                          rx,
  output logic                          deser_enable,
  output logic [$clog2(DATA_WIDTH)-1:0] data_index,
  output logic                          sampled_bit,
  output logic                          rx_busy,
  output logic                          rx_done,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_error,
`endif
  output logic                          frame_error
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          r_state, w_state_nxt;
  logic            r_rx_meta, r_rx_s;
  logic [TW-1:0]   r_tick_cnt, w_tick_nxt;
  logic [IW-1:0]   r_bit_cnt, w_bit_nxt;
  logic            r_deser_en, w_deser_en;
  logic [IW-1:0]   r_data_index, w_data_index;
  logic            r_sampled_bit, w_sampled_bit;
  logic            r_busy;
  logic            r_done, w_done;
  logic            r_ferr, w_ferr;
`ifdef UART_RX_PARITY_EN
  logic            r_par, w_par_nxt;
  logic            r_par_bad, w_par_bad_nxt;
  logic            r_perr, w_perr;
`endif

  // rx is asynchronous to clk; idle level is high so the synchronizer resets to 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_tick_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_deser_en    <= 1'b0;
      r_data_index  <= '0;
      r_sampled_bit <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_ferr        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par         <= 1'b0;
      r_par_bad     <= 1'b0;
      r_perr        <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_tick_cnt    <= w_tick_nxt;
      r_bit_cnt     <= w_bit_nxt;
      r_deser_en    <= w_deser_en;
      r_data_index  <= w_data_index;
      r_sampled_bit <= w_sampled_bit;
      r_busy        <= (r_state != IDLE);
      r_done        <= w_done;
      r_ferr        <= w_ferr;
`ifdef UART_RX_PARITY_EN
      r_par         <= w_par_nxt;
      r_par_bad     <= w_par_bad_nxt;
      r_perr        <= w_perr;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tick_nxt    = r_tick_cnt;
    w_bit_nxt     = r_bit_cnt;
    w_deser_en    = 1'b0;
    w_data_index  = r_data_index;
    w_sampled_bit = r_sampled_bit;
    w_done        = 1'b0;
    w_ferr        = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt     = r_par;
    w_par_bad_nxt = r_par_bad;
    w_perr        = 1'b0;
`endif
    case (r_state)
      IDLE: if (!r_rx_s) w_state_nxt = START;
      START: begin
        if (s_tick) begin
          if (r_tick_cnt == TICK_MID) begin
            if (!r_rx_s) begin
              w_state_nxt = DATA;
              w_bit_nxt   = '0;
`ifdef UART_RX_PARITY_EN
              w_par_nxt   = 1'b0;
`endif
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (r_tick_cnt == TICK_LAST) begin
            w_deser_en    = 1'b1;
            w_data_index  = r_bit_cnt;
            w_sampled_bit = r_rx_s;
            w_tick_nxt    = '0;
`ifdef UART_RX_PARITY_EN
            w_par_nxt     = r_par ^ r_rx_s;
`endif
            if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = PARITY;
`else
              w_state_nxt = STOP;
`endif
            end else begin
              w_bit_nxt = r_bit_cnt + 1'b1;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (r_tick_cnt == TICK_LAST) begin
            // held until STOP so the error pulses with rx_done
            w_par_bad_nxt = r_rx_s ^ r_par;
            w_state_nxt   = STOP;
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (r_tick_cnt == TICK_LAST) begin
            w_done      = 1'b1;
            w_ferr      = ~r_rx_s;
`ifdef UART_RX_PARITY_EN
            w_perr      = r_par_bad;
`endif
            w_state_nxt = IDLE;
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt != r_state) w_tick_nxt = '0;
  end

  assign deser_enable = r_deser_en;
  assign data_index   = r_data_index;
  assign sampled_bit  = r_sampled_bit;
  assign rx_busy      = r_busy;
  assign rx_done      = r_done;
  assign frame_error  = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign parity_error = r_perr;
`endif

endmodule

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
Receive-side sequencer for the UART receiver. Detects the start bit on the serial line using an oversampling tick and samples each data bit at mid-bit. For each data bit it drives the deserializer's enable, bit index and sampled bit. It then checks the stop bit (and optionally parity) and signals frame completion to the processor-side logic.

Parameters:
DATA_WIDTH, 8, data bits per frame; also sets the data_index width.
OVERSAMPLE, 16, s_tick pulses per bit period; must be even and >= 4.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous reset, active-low
s_tick  input  1  baud oversample strobe; 1-cycle pulse, OVERSAMPLE per bit
rx  input  1  raw serial line, idle high, asynchronous to clk
deser_enable  output  1  1-cycle write strobe to the deserializer
data_index  output  $clog2(DATA_WIDTH)  bit position for the current write (0 = LSB)
sampled_bit  output  1  bit value for the current write
rx_busy  output  1  high in any state other than IDLE
rx_done  output  1  1-cycle pulse at end of frame; parallel data is valid in the same cycle
frame_error  output  1  1-cycle pulse coincident with rx_done when the stop bit sampled 0

Behaviour:
- rx passes through a 2-flop synchronizer (rx_s), which resets to 1. All decisions use rx_s, so the line-to-decision latency is 2 clk cycles.
- Reset values: all outputs 0, state IDLE, tick_cnt 0, bit_cnt 0. An asynchronous reset mid-frame aborts the frame immediately; no rx_done is produced for the aborted frame.
- tick_cnt width is $clog2(OVERSAMPLE). It advances only on s_tick and is cleared on every state transition.
- IDLE:
  - If rx_s == 0, go to START with tick_cnt = 0.
  - s_tick is not required to leave IDLE.
- START:
  - On the s_tick where tick_cnt == OVERSAMPLE/2-1 (mid start bit):
    - if rx_s == 0, go to DATA with bit_cnt = 0;
    - otherwise treat it as a glitch and return to IDLE with no outputs asserted.
- DATA:
  - On the s_tick where tick_cnt == OVERSAMPLE-1 (mid data bit), in the same cycle: deser_enable = 1, data_index = bit_cnt, sampled_bit = rx_s.
  - If bit_cnt == DATA_WIDTH-1, go to STOP (or PARITY when the optional feature is enabled). Otherwise bit_cnt increments.
  - Bits are received LSB first.
- STOP:
  - On the s_tick where tick_cnt == OVERSAMPLE-1, pulse rx_done and go to IDLE.
  - frame_error = ~rx_s in the same cycle.
- deser_enable, rx_done and frame_error are registered and high for exactly one clk cycle. data_index and sampled_bit hold their last value when deser_enable is low.
- rx_busy = (state != IDLE), registered.
- s_tick asserted continuously (every clk) is legal; the sequence is the same, just compressed.
- Break condition (rx held low): STOP reports frame_error, the FSM returns to IDLE, and it re-enters START on the next cycle. Repeated errored frames are the intended behaviour.
- rx changes between s_ticks are ignored except for the IDLE start detect.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: a PARITY state sits between DATA and STOP.
  - On the s_tick where tick_cnt == OVERSAMPLE-1, the controller samples rx_s and compares it to the even parity of the data bits (XOR accumulated as each bit is written).
  - Adds output parity_error (1 bit, reset 0). It pulses coincident with rx_done when the parity sample mismatches.
  - Frame length is 1 + DATA_WIDTH + 1 + 1 bits.
- Undefined: no PARITY state, no parity_error port, frame is 1 + DATA_WIDTH + 1 bits.

Test Plan:
1. Reset released, rx=1, s_tick every 4 clk:
   - rx_busy stays 0;
   - no deser_enable for 1000 cycles.
2. Frame 0xA5 (start 0; bits 1,0,1,0,0,1,0,1; stop 1):
   - exactly 8 deser_enable pulses with data_index 0..7 and sampled_bit 1,0,1,0,0,1,0,1;
   - one rx_done;
   - frame_error = 0;
   - rx_busy falls the cycle after rx_done.
3. Start glitch (rx low for 3 ticks, then high):
   - controller returns to IDLE;
   - no deser_enable, no rx_done.
4. Frame 0x3C with stop bit = 0:
   - rx_done and frame_error pulse in the same cycle;
   - 8 data writes are still correct.
5. reset_n asserted after data bit 4 of a frame:
   - all outputs 0 immediately;
   - next clean frame 0x5A is received correctly.
6. UART_RX_PARITY_EN:
   - 0xA5 with parity bit 0 -> parity_error = 0;
   - same frame with parity bit 1 -> parity_error pulses with rx_done.
